// File: rtl/note_scheduler.sv
// Rhythm-game chart sequencer: walks a chart ROM, paces entries with a game-tick
// divider, and hands lane spawn requests to a valid/ready consumer.
module note_scheduler #(
  parameter int TICK_DIV = 50000,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              game_state,
  input  logic              start,
  output logic [ADDR_W-1:0] chart_addr,
  input  logic [15:0]       chart_data,
  output logic              spawn_valid,
  output logic [3:0]        spawn_lanes,
  input  logic              spawn_ready,
  output logic [15:0]       song_pos,
  output logic              busy,
  output logic              done
);

  localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_SPAWN, S_WAIT, S_FIN
  } state_t;

  state_t            state, state_nxt;
  logic [DIV_W-1:0]  div_cnt;
  logic [11:0]       delta_cnt;
  logic              run;
  logic              tick;
  logic              start_acc;
  logic              wait_done;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Everything outside IDLE is frozen while paused; run marks a live cycle.
  assign run       = (state != S_IDLE) && !game_state;
  assign tick      = run && (div_cnt == DIV_LAST);
  assign start_acc = (state == S_IDLE) && start;
  // A count of 1 finishes on the tick itself, so no idle cycle follows the last tick.
  assign wait_done = (delta_cnt == 12'd0) || (tick && (delta_cnt == 12'd1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FETCH;
      S_FETCH: if (!game_state) state_nxt = S_LOAD;
      S_LOAD:
        if (!game_state) begin
          if (chart_data == 16'h0000)         state_nxt = S_FIN;
          else if (chart_data[15:12] != 4'h0) state_nxt = S_SPAWN;
          else                                state_nxt = S_WAIT;
        end
      S_SPAWN: if (!game_state && spawn_ready) state_nxt = S_WAIT;
      S_WAIT:
        if (run && wait_done)
          state_nxt = (chart_addr == ADDR_LAST) ? S_FIN : S_FETCH;
      S_FIN:   if (!game_state) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state != S_IDLE);
    spawn_valid = (state == S_SPAWN) && !game_state;
    done        = (state == S_FIN) && !game_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      song_pos    <= '0;
      chart_addr  <= '0;
      delta_cnt   <= '0;
      spawn_lanes <= '0;
    end else begin
      if (start_acc)  div_cnt <= '0;
      else if (run)   div_cnt <= tick ? '0 : div_cnt + 1'b1;

      if (start_acc)  song_pos <= '0;
      else if (tick)  song_pos <= sat_inc16(song_pos);

      // The last chart slot ends the song rather than wrapping to address 0.
      if (start_acc)
        chart_addr <= '0;
      else if ((state == S_WAIT) && run && wait_done && (chart_addr != ADDR_LAST))
        chart_addr <= chart_addr + 1'b1;

      if ((state == S_LOAD) && run)
        delta_cnt <= chart_data[11:0];
      else if ((state == S_WAIT) && tick && (delta_cnt != 12'd0))
        delta_cnt <= delta_cnt - 12'd1;

      if ((state == S_LOAD) && run) spawn_lanes <= chart_data[15:12];
    end
  end

endmodule

// File: tb/tb_note_scheduler.sv
// Bench for note_scheduler: a running-time model predicts every observable per
// live cycle; pauses simply stretch wall time without changing that timeline.
module tb_note_scheduler;

  localparam int TD   = 4;
  localparam int AW   = 2;
  localparam int NW   = 4;
  localparam int MAXR = 2048;

  logic          clk = 1'b0;
  logic          rst_n, game_state, start, spawn_ready;
  logic [AW-1:0] chart_addr;
  logic [15:0]   chart_data;
  logic          spawn_valid;
  logic [3:0]    spawn_lanes;
  logic [15:0]   song_pos;
  logic          busy, done;

  logic [15:0]   rom [NW];
  bit            rdy [MAXR];
  bit            exp_sv [MAXR];
  logic [3:0]    exp_lanes [MAXR];
  logic [AW-1:0] exp_addr [MAXR];
  int            r_f, n_spawn_exp;
  int            n_chk, n_pass, n_fail;

  always #5 clk = ~clk;

  always_ff @(posedge clk) chart_data <= rom[chart_addr];

  note_scheduler #(.TICK_DIV(TD), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .game_state (game_state),
    .start      (start),
    .chart_addr (chart_addr),
    .chart_data (chart_data),
    .spawn_valid(spawn_valid),
    .spawn_lanes(spawn_lanes),
    .spawn_ready(spawn_ready),
    .song_pos   (song_pos),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic set_rdy(input int mode);
    for (int i = 0; i < MAXR; i++) begin
      case (mode)
        0:       rdy[i] = 1'b1;
        1:       rdy[i] = !(i >= 2 && i <= 6);
        default: rdy[i] = ($urandom_range(99) < 60) || (i % 8 == 7);
      endcase
    end
  endtask

  // Timeline in live (unpaused) cycles, index 0 = first cycle after start.
  // Ticks land on live cycles t with (t+1) % TD == 0.
  task automatic model_build();
    int r, a, d, t0, te;
    logic [3:0]  m;
    logic [15:0] w;
    bit fin;
    for (int i = 0; i < MAXR; i++) begin
      exp_sv[i] = 1'b0; exp_lanes[i] = '0; exp_addr[i] = '0;
    end
    r = 0; a = 0; fin = 1'b0; n_spawn_exp = 0; r_f = 0;
    while (!fin && r < MAXR - 64) begin
      exp_addr[r] = AW'(a); exp_addr[r+1] = AW'(a);
      w = rom[a];
      r += 2;
      if (w == 16'h0000) begin
        exp_addr[r] = AW'(a); r_f = r; fin = 1'b1;
      end else begin
        m = w[15:12];
        d = int'(w[11:0]);
        if (m != 4'h0) begin
          while (!rdy[r] && r < MAXR - 64) begin
            exp_sv[r] = 1'b1; exp_lanes[r] = m; exp_addr[r] = AW'(a); r++;
          end
          exp_sv[r] = 1'b1; exp_lanes[r] = m; exp_addr[r] = AW'(a); r++;
          n_spawn_exp++;
        end
        if (d == 0) begin
          exp_addr[r] = AW'(a); r++;
        end else begin
          t0 = r + (TD - (r + 1) % TD) % TD;
          te = t0 + (d - 1) * TD;
          for (int q = r; q <= te; q++) exp_addr[q] = AW'(a);
          r = te + 1;
        end
        if (a == NW - 1) begin
          exp_addr[r] = AW'(a); r_f = r; fin = 1'b1;
        end else begin
          a++;
        end
      end
    end
  endtask

  // pmode: 0 never paused, 1 random pauses, 2 one 20-cycle pause at live cycle 5.
  task automatic run_song(input int pmode, input bit noise, input int abort_at,
                          output int done_wall, output int nsp);
    int rcnt, wall, pblk;
    bit finished, aborted, used, running;
    model_build();
    rcnt = 0; wall = 0; pblk = 0; nsp = 0; done_wall = -1;
    finished = 1'b0; aborted = 1'b0; used = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    game_state = (pmode == 1) ? ($urandom_range(1) == 1) : 1'b0;
    spawn_ready = 1'b0;
    while (!finished && wall < 4000) begin
      @(posedge clk); #1;
      start = noise && ($urandom_range(3) == 0);
      if (pmode == 1)       game_state = ($urandom_range(99) < 15);
      else if (pmode == 2) begin
        if (pblk > 0) begin game_state = 1'b1; pblk--; end
        else if (rcnt == 5 && !used) begin game_state = 1'b1; pblk = 19; used = 1'b1; end
        else game_state = 1'b0;
      end else game_state = 1'b0;
      spawn_ready = rdy[rcnt];
      @(negedge clk);
      running = !game_state;
      chk("busy", 32'(busy), 32'(1));
      chk("chart_addr", 32'(chart_addr), 32'(exp_addr[rcnt]));
      chk("song_pos", 32'(song_pos), 32'(sat16(rcnt / TD)));
      chk("spawn_valid", 32'(spawn_valid), 32'(running && exp_sv[rcnt]));
      if (running && exp_sv[rcnt]) chk("spawn_lanes", 32'(spawn_lanes), 32'(exp_lanes[rcnt]));
      chk("done", 32'(done), 32'(running && rcnt == r_f));
      if (spawn_valid && spawn_ready) nsp++;
      if (running && rcnt == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_valid", 32'(spawn_valid), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_addr", 32'(chart_addr), 32'(0));
        chk("rst_song_pos", 32'(song_pos), 32'(0));
        chk("rst_lanes", 32'(spawn_lanes), 32'(0));
        @(posedge clk); #1;
        start = 1'b0; game_state = 1'b0; rst_n = 1'b1;
        repeat (3) begin
          @(negedge clk);
          chk("post_rst_busy", 32'(busy), 32'(0));
          chk("post_rst_done", 32'(done), 32'(0));
        end
        aborted = 1'b1; finished = 1'b1;
      end else if (running && rcnt == r_f) begin
        done_wall = wall; finished = 1'b1;
      end
      if (running) rcnt++;
      wall++;
    end
    chk("run_completes", 32'(finished), 32'(1));
    if (!aborted) begin
      @(posedge clk); #1;
      start = 1'b0; game_state = 1'b0; spawn_ready = 1'b0;
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'(0));
      chk("idle_done", 32'(done), 32'(0));
      chk("final_song_pos", 32'(song_pos), 32'(sat16((r_f + 1) / TD)));
      chk("spawn_count", 32'(nsp), 32'(n_spawn_exp));
    end
  endtask

  initial begin
    int dw_a, dw, nsp;
    n_chk = 0; n_pass = 0; n_fail = 0;
    rst_n = 1'b0; game_state = 1'b0; start = 1'b0; spawn_ready = 1'b0;
    rom[0] = 16'h1003; rom[1] = 16'h2000; rom[2] = 16'h0000; rom[3] = 16'h0000;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_done", 32'(done), 32'(0));
    chk("reset_valid", 32'(spawn_valid), 32'(0));
    chk("reset_lanes", 32'(spawn_lanes), 32'(0));
    chk("reset_addr", 32'(chart_addr), 32'(0));
    chk("reset_song_pos", 32'(song_pos), 32'(0));
    @(posedge clk); #1 rst_n = 1'b1;

    // Reference chart, consumer always ready.
    set_rdy(0);
    run_song(0, 1'b0, -1, dw_a, nsp);
    chk("a_spawns", 32'(nsp), 32'(2));
    chk("a_done_wall", 32'(dw_a), 32'(18));

    // Consumer stalls five live cycles during the first spawn.
    set_rdy(1);
    run_song(0, 1'b0, -1, dw, nsp);

    // 20-cycle pause inside WAIT delays done by exactly 20.
    set_rdy(0);
    run_song(2, 1'b0, -1, dw, nsp);
    chk("c_done_delay", 32'(dw), 32'(dw_a + 20));

    // Full chart without end marker stops at the last slot.
    rom[0] = 16'h1001; rom[1] = 16'h2002; rom[2] = 16'h4000; rom[3] = 16'h8001;
    run_song(0, 1'b0, -1, dw, nsp);
    chk("d_spawns", 32'(nsp), 32'(4));

    // Abort in WAIT, then replay from address 0.
    rom[0] = 16'h1003; rom[1] = 16'h2000; rom[2] = 16'h0000; rom[3] = 16'h0000;
    run_song(0, 1'b0, 5, dw, nsp);
    run_song(0, 1'b0, -1, dw, nsp);
    chk("e_replay_wall", 32'(dw), 32'(dw_a));

    // Stray start pulses while busy change nothing.
    run_song(0, 1'b1, -1, dw, nsp);
    chk("f_noise_wall", 32'(dw), 32'(dw_a));

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < NW; i++) begin
        if ($urandom_range(99) < 20) rom[i] = 16'h0000;
        else rom[i] = {4'($urandom_range(15)), 12'($urandom_range(5))};
      end
      set_rdy(2);
      run_song(1, 1'b1, -1, dw, nsp);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
